// File: rtl/shake_hand_arb.sv
// shake_hand_arb: round-robin arbiter sharing one ready/ack receiver among N senders,
// with a per-transfer timeout that frees the receiver if it never acknowledges.
module shake_hand_arb #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16,
  parameter int IDW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_ready_i,
  input  logic [N*DW-1:0] req_din_i,
  output logic [N-1:0]    req_ack_o,
  output logic            out_ready_o,
  output logic [DW-1:0]   out_din_o,
  input  logic            out_ack_i,
  output logic [IDW-1:0]  grant_id_o,
  output logic            busy_o,
  output logic            timeout_err_o
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, gid_q, gid_d, pick, nxt_ptr;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  din_q, din_d, din_sel;
  logic [N-1:0]   ack_q, ack_d;
  logic           rdy_q, rdy_d, busy_q, busy_d, terr_q, terr_d, hit;
  logic [IDW:0]   sum;
  logic [2*N-1:0] dbl;
  // Rotating the request vector by ptr makes the lowest set bit the round-robin winner.
  assign dbl = {req_ready_i, req_ready_i} >> ptr_q;
  always_comb begin
    hit = 1'b0;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        hit = 1'b1;
        sum = (IDW+1)'(k) + {1'b0, ptr_q};
      end
    end
    pick = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
    din_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (pick == IDW'(k)) din_sel = req_din_i[k*DW +: DW];
    end
  end
  assign nxt_ptr = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    ack_d   = ack_q;
    rdy_d   = rdy_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          din_d   = din_sel;
          gid_d   = pick;
          cnt_d   = '0;
          rdy_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ack_i) begin
          rdy_d   = 1'b0;
          ack_d   = N'(1) << gid_q;
          state_d = RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdy_d   = 1'b0;
          terr_d  = 1'b1;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!out_ack_i) begin
          ack_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end
  assign req_ack_o     = ack_q;
  assign out_ready_o   = rdy_q;
  assign out_din_o     = din_q;
  assign grant_id_o    = gid_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = terr_q;
endmodule

// File: tb/tb_shake_hand_arb.sv
// tb_shake_hand_arb: randomized scoreboard bench; stimulus predicts each grant and ack from a
// transaction-level round-robin model, an independent monitor checks what the DUT presents.
module tb_shake_hand_arb;
  localparam int N = 4, DW = 8, TO = 16, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_ready = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0] req_ack;
  logic out_ready, out_ack = 1'b0, busy, timeout_err;
  logic [DW-1:0] out_din;
  logic [IDW-1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  int qg[$];
  int qa[$];
  bit [N-1:0] pend = '0;
  logic [DW-1:0] data [N];
  int mptr = 0;

  shake_hand_arb #(.N(N), .DW(DW), .TIMEOUT(TO), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_ready_i(req_ready), .req_din_i(req_din),
    .req_ack_o(req_ack), .out_ready_o(out_ready), .out_din_o(out_din),
    .out_ack_i(out_ack), .grant_id_o(grant_id), .busy_o(busy),
    .timeout_err_o(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [DW-1:0] d);
    pend[i] = 1'b1;
    data[i] = d;
    req_ready[i] = 1'b1;
    req_din[i*DW +: DW] = d;
  endtask

  // One transfer: ack after d cycles of out_ready (d >= TO means never ack), hold ack h cycles.
  task automatic xfer(input int d, input int h);
    int g, c;
    g = model_pick();
    qg.push_back(g * 256 + int'(data[g]));
    if (d < TO) qa.push_back(g);
    @(negedge clk);
    chk("grant_latency", {busy, out_ready}, 2'b11);
    chk("no_stale_terr", timeout_err, 0);
    if (d < TO) begin
      repeat (d) @(negedge clk);
      chk("ready_held", out_ready, 1);
      out_ack = 1'b1;
      repeat (h) begin
        @(negedge clk);
        chk("req_ack_hold", req_ack, N'(1) << g);
        chk("ready_low_in_ack", out_ready, 0);
        chk("no_terr_on_ack", timeout_err, 0);
      end
      out_ack = 1'b0;
      req_ready[g] = 1'b0;
      pend[g] = 1'b0;
      @(negedge clk);
      chk("release_idle", {busy, req_ack}, '0);
    end else begin
      c = 1;
      while (c < TO + 4) begin
        @(negedge clk);
        if (!out_ready) break;
        c++;
      end
      chk("timeout_ready_cycles", c, TO);
      chk("timeout_err_pulse", timeout_err, 1);
      chk("timeout_no_ack", {busy, req_ack}, '0);
    end
    mptr = (g + 1) % N;
  endtask

  initial begin : monitor
    logic prev_rdy, cur;
    int e;
    logic [N-1:0] prev_ack;
    prev_rdy = 1'b0;
    prev_ack = '0;
    forever begin
      @(negedge clk);
      cur = out_ready;
      if (cur && !prev_rdy) begin
        if (qg.size() == 0) chk("grant_unexpected", {grant_id, out_din}, '1);
        else begin
          e = qg.pop_front();
          chk("grant_id", grant_id, e / 256);
          chk("out_din", out_din, e % 256);
        end
      end
      if (req_ack != '0 && prev_ack == '0) begin
        if (qa.size() == 0) chk("ack_unexpected", req_ack, 0);
        else begin
          e = qa.pop_front();
          chk("req_ack_onehot", req_ack, N'(1) << e);
        end
      end
      prev_rdy = cur;
      prev_ack = req_ack;
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    #3;
    chk("reset_outputs", {out_ready, req_ack, out_din, grant_id, busy, timeout_err}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_request", {busy, out_ready}, 2'b00);
    end
    raise(0, 8'hAA);
    xfer(0, 1);
    raise(0, 8'h10); raise(1, 8'h21); raise(2, 8'h32); raise(3, 8'h43);
    repeat (4) xfer(0, 1);
    raise(0, 8'h10);
    xfer(0, 1);
    raise(1, 8'h5A); raise(2, 8'hC3);
    xfer(TO, 0);
    xfer(0, 1);
    xfer(TO - 1, 1);
    raise(3, 8'h77); raise(0, 8'h01);
    xfer(1, 5);
    xfer(0, 1);
    raise(0, 8'hE0); raise(2, 8'hE2);
    g = model_pick();
    qg.push_back(g * 256 + int'(data[g]));
    @(negedge clk);
    chk("pre_reset_grant", out_ready, 1);
    #2 rst = 1'b1;
    #1 chk("async_reset", {out_ready, req_ack, out_din, grant_id, busy, timeout_err}, '0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    xfer(0, 1);
    xfer(2, 2);
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(2) == 0) raise(i, DW'($urandom));
      if (pend == '0) raise($urandom_range(N - 1), DW'($urandom));
      case ($urandom_range(9))
        0, 1:    xfer(TO, 0);
        2:       xfer(TO - 1, 1 + $urandom_range(2));
        default: xfer($urandom_range(3), 1 + $urandom_range(2));
      endcase
    end
    req_ready = '0;
    pend = '0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", qg.size() + qa.size(), 0);
    chk("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shake_hand_arb.md
# shake_hand_arb

Round-robin arbiter that shares one `shake_hand_recv`-style ready/ack receiver among N independent senders. Each sender presents a byte with a `ready` level. The arbiter grants one sender and latches its byte. It then runs the ready/ack handshake toward the receiver and returns a per-requester ack. A timeout releases the shared receiver if it never acknowledges.

## Interface
- `N`, 4: number of requesters (2..8).
- `DW`, 8: data width.
- `TIMEOUT`, 16: maximum SEND cycles without `out_ack` before abort (≥2).
- `IDW`, 2: width of `grant_id`; must equal clog2(N).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_ready`  in  N  per-requester request level.
- `req_din`  in  N*DW  requester i's data on bits [i*DW +: DW].
- `req_ack`  out  N  per-requester completion ack (one-hot or zero).
- `out_ready`  out  1  ready to the shared receiver.
- `out_din`  out  DW  data to the shared receiver.
- `out_ack`  in  1  ack from the shared receiver.
- `grant_id`  out  IDW  index of the current or last granted requester.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- All outputs are registered. States: IDLE, SEND, RELEASE.
- Reset (async, any state) forces:
  - state=IDLE, rr pointer `ptr`=0;
  - `out_ready`=0, `out_din`=0, `req_ack`=0, `grant_id`=0, `busy`=0, `timeout_err`=0;
  - timeout counter=0.
- **IDLE**
  - If any `req_ready` is high, grant the first high index searching ptr, ptr+1, … mod N.
  - Latch `out_din`←`req_din[g]` and `grant_id`←g, clear the counter, set `out_ready`=1, go to SEND.
  - Otherwise stay in IDLE.
- **SEND**
  - `out_ready`=1 and `out_din` are held constant.
  - Requester inputs are ignored; a requester dropping `req_ready` does not cancel the transfer.
  - If `out_ack`=1: `out_ready`←0, `req_ack[g]`←1, go to RELEASE.
  - Else if the counter equals TIMEOUT-1: `out_ready`←0, `timeout_err`←1 for one cycle, ptr←(g+1) mod N, go to IDLE. No `req_ack` is given.
  - Else the counter increments.
  - When `out_ack` and the timeout occur on the same edge, the ack wins.
- **RELEASE**
  - `out_ready`=0 and `req_ack[g]` stays 1.
  - When `out_ack`=0: `req_ack`←0, ptr←(g+1) mod N, go to IDLE.
  - `req_ack` is high for at least one cycle and remains high as long as `out_ack` stays high.
- Requester contract:
  - Hold `req_ready` and `req_din` until `req_ack` is seen.
  - Drop `req_ready` no later than the edge at which `req_ack` falls.
  - The arbiter may re-grant a requester whose `req_ready` is still high in IDLE.
- `grant_id` and `out_din` keep their last values in IDLE.

## Timing
- Grant latency: `req_ready` sampled high at IDLE edge E0 → `out_ready`=1 and valid `out_din` from E0 onward (1 cycle after the request is visible).
- Ack path: `out_ack` sampled high at edge E1 → `out_ready`=0 and `req_ack[g]`=1 after E1.
- Release path: `out_ack` sampled low at edge E2 (≥E1+1) → `req_ack`=0 and state=IDLE after E2. The earliest next grant is at E2+1.
- Minimum back-to-back transfer period is 4 cycles with a 1-cycle-ack receiver: grant, ack, release, idle.
- Timeout: if no ack, `out_ready` is high for exactly TIMEOUT cycles. `timeout_err` is high for the one cycle after the abort edge.
- Fairness: with all N requesters continuously requesting, grants cycle 0,1,…,N-1,0.
- Reset mid-SEND or mid-RELEASE drops `out_ready` and `req_ack` immediately (asynchronously).

## Test plan
- **Single request.** Reset, then req_ready=0001 with req_din[7:0]=8'hAA; receiver acks 1 cycle after `out_ready` and releases 1 cycle later → out_din=8'hAA, grant_id=0, one `req_ack[0]` pulse, busy returns to 0.
- **Round-robin.** All four requesters request with data 8'h10, 8'h21, 8'h32, 8'h43 and each deasserts after its ack → `out_din` sequence 10, 21, 32, 43 with grant_id 0, 1, 2, 3; then requester 0 again re-requests → granted after 3.
- **Timeout.** TIMEOUT=16, `out_ack` held 0 → `out_ready` high for exactly 16 cycles, one-cycle `timeout_err`, no `req_ack`, next grant goes to (g+1) mod N.
- **Ack at timeout edge.** `out_ack` rises on the cycle the counter reaches 15 → `req_ack` is given and `timeout_err` stays 0.
- **Long ack.** `out_ack` held high for 5 cycles → `req_ack` is high for the full 5 cycles, `out_ready` is 0 throughout, and no new grant occurs until `out_ack` falls.
- **Reset mid-transfer.** Assert `rst` during SEND → all outputs are 0 immediately; after release, the first grant starts from index 0.
